// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and the
// software-reset decode reused by devtbl-based board tops.
package rstseq_pkg;

    typedef enum logic [2:0] {
        RSTSEQ_HOLD = 3'd0,
        RSTSEQ_CNT  = 3'd1,
        RSTSEQ_WAIT = 3'd2,
        RSTSEQ_RUN  = 3'd3,
        RSTSEQ_COLD = 3'd4,
        RSTSEQ_OFF  = 3'd5
    } rstseq_state_t;

    function automatic logic sw_cold(input logic swrst0, input logic swrst1);
        return swrst0 & swrst1;
    endfunction

    function automatic logic sw_warm(input logic swrst0, input logic swrst1, input logic cpurst);
        return (!swrst0 & swrst1) | cpurst;
    endfunction

    function automatic logic sw_off(input logic swrst0, input logic swrst1);
        return swrst0 & !swrst1;
    endfunction

    // Index width that stays legal for a single-domain build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rstseq_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear; the output is
// forced low while rst_n is asserted.
module rstseq_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/rstseq.sv
// Reset sequencer: releases reset domains in index order after a hold period
// and optional upstream ready, and handles cold/warm/power-off requests.
module rstseq
    import rstseq_pkg::*;
#(
    parameter int                  DOMCOUNT   = 3,
    parameter int                  CNTRBITSZ  = 16,
    parameter int                  RSTCYCLES  = 'hffff,
    parameter int                  RDYTIMEOUT = 'hffff,
    parameter logic [DOMCOUNT-1:0] RDYMASK    = {DOMCOUNT{1'b0}},
    parameter int                  WARMDOM    = 1,
    parameter int                  GSRCYCLES  = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                pll_locked_i,
    input  logic                swrst0_i,
    input  logic                swrst1_i,
    input  logic                cpurst_i,
    input  logic [DOMCOUNT-1:0] dom_rdy_i,
    output logic [DOMCOUNT-1:0] dom_rst_o,
    output logic                gsr_o,
    output logic                pwroff_o,
    output logic                err_o,
    output logic                busy_o
);

    localparam int IDXW = idx_width(DOMCOUNT);
    localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(DOMCOUNT - 1);
    localparam logic [IDXW-1:0]      WARM_IDX = IDXW'(WARMDOM);
    localparam logic [CNTRBITSZ-1:0] RST_LOAD = CNTRBITSZ'(RSTCYCLES - 1);
    localparam logic [CNTRBITSZ-1:0] RDY_LOAD = CNTRBITSZ'(RDYTIMEOUT - 1);
    localparam logic [CNTRBITSZ-1:0] GSR_LOAD = CNTRBITSZ'(GSRCYCLES - 1);

    rstseq_state_t         state_reg, state_next;
    logic [IDXW-1:0]       idx_reg, idx_next;
    logic [CNTRBITSZ-1:0]  cntr_reg, cntr_next;
    logic [DOMCOUNT-1:0]   dom_rst_reg, dom_rst_next;
    logic                  gsr_reg, gsr_next;
    logic                  pwroff_reg, pwroff_next;
    logic                  err_reg, err_next;
    logic                  busy_reg, busy_next;
    logic                  pll_sync;
    logic                  rdy_ok;
    logic [DOMCOUNT-1:0]   warm_mask;

    wire cold_req = sw_cold(swrst0_i, swrst1_i);
    wire warm_req = sw_warm(swrst0_i, swrst1_i, cpurst_i);
    wire off_req  = sw_off(swrst0_i, swrst1_i);

    rstseq_sync2 #(.WIDTH(1)) u_pll_sync (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .d     (pll_locked_i),
        .q     (pll_sync)
    );

    // Domains at or above WARMDOM are the ones a warm reset re-asserts.
    generate
        for (genvar gi = 0; gi < DOMCOUNT; gi++) begin : g_warm_mask
            assign warm_mask[gi] = (gi >= WARMDOM);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RSTSEQ_HOLD;
            idx_reg     <= '0;
            cntr_reg    <= '0;
            dom_rst_reg <= '1;
            gsr_reg     <= 1'b0;
            pwroff_reg  <= 1'b0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cntr_reg    <= cntr_next;
            dom_rst_reg <= dom_rst_next;
            gsr_reg     <= gsr_next;
            pwroff_reg  <= pwroff_next;
            err_reg     <= err_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cntr_next    = cntr_reg;
        dom_rst_next = dom_rst_reg;
        gsr_next     = gsr_reg;
        pwroff_next  = pwroff_reg;
        err_next     = err_reg;
        rdy_ok       = (idx_reg == LAST_IDX) || !RDYMASK[idx_reg] || dom_rdy_i[idx_reg];

        if (state_reg == RSTSEQ_OFF) begin
            dom_rst_next = '1;
        end else if (off_req) begin
            state_next   = RSTSEQ_OFF;
            pwroff_next  = 1'b1;
            gsr_next     = 1'b0;
            dom_rst_next = '1;
        end else if (cold_req) begin
            state_next   = RSTSEQ_COLD;
            gsr_next     = 1'b1;
            cntr_next    = GSR_LOAD;
            idx_next     = '0;
            dom_rst_next = '1;
        end else begin
            case (state_reg)
                RSTSEQ_HOLD: begin
                    dom_rst_next = '1;
                    if (pll_sync) begin
                        state_next = RSTSEQ_CNT;
                        idx_next   = '0;
                        cntr_next  = RST_LOAD;
                    end
                end
                RSTSEQ_COLD: begin
                    if (cntr_reg == '0) begin
                        gsr_next   = 1'b0;
                        state_next = RSTSEQ_HOLD;
                    end else begin
                        cntr_next = cntr_reg - 1'b1;
                    end
                end
                RSTSEQ_CNT, RSTSEQ_WAIT, RSTSEQ_RUN: begin
                    if (!pll_sync) begin
                        state_next   = RSTSEQ_HOLD;
                        idx_next     = '0;
                        cntr_next    = '0;
                        dom_rst_next = '1;
                    end else if (warm_req && idx_reg >= WARM_IDX) begin
                        state_next   = RSTSEQ_CNT;
                        idx_next     = WARM_IDX;
                        cntr_next    = RST_LOAD;
                        dom_rst_next = dom_rst_reg | warm_mask;
                    end else if (state_reg == RSTSEQ_CNT) begin
                        // A warm request arriving before WARMDOM only stretches the hold.
                        if (warm_req) begin
                            cntr_next = RST_LOAD;
                        end else if (cntr_reg == '0) begin
                            dom_rst_next[idx_reg] = 1'b0;
                            state_next = RSTSEQ_WAIT;
                            cntr_next  = RDY_LOAD;
                        end else begin
                            cntr_next = cntr_reg - 1'b1;
                        end
                    end else if (state_reg == RSTSEQ_WAIT) begin
                        if (rdy_ok || cntr_reg == '0) begin
                            if (!rdy_ok) begin
                                err_next = 1'b1;
                            end
                            if (idx_reg == LAST_IDX) begin
                                state_next = RSTSEQ_RUN;
                            end else begin
                                state_next = RSTSEQ_CNT;
                                idx_next   = idx_reg + 1'b1;
                                cntr_next  = RST_LOAD;
                            end
                        end else begin
                            cntr_next = cntr_reg - 1'b1;
                        end
                    end else begin
                        dom_rst_next = '0;
                    end
                end
                default: begin
                    state_next   = RSTSEQ_HOLD;
                    idx_next     = '0;
                    cntr_next    = '0;
                    dom_rst_next = '1;
                end
            endcase
        end

        busy_next = (state_next != RSTSEQ_RUN);
    end

    assign dom_rst_o = dom_rst_reg;
    assign gsr_o     = gsr_reg;
    assign pwroff_o  = pwroff_reg;
    assign err_o     = err_reg;
    assign busy_o    = busy_reg;

endmodule
